// File: rtl/sine_wave_meas.sv
// sine_wave_meas: period and amplitude monitor for offset-binary sine sample streams
// Build option SINE_MEAS_HYST_EN: hysteresis crossing detector (+-HYST LSBs around 128).
// Ports: Clk, Rst (sync, active-high); din/din_vld sample input;
//        period, vmax, vmin, amp_pp (last measurement); meas_valid, timeout (pulses); locked.
module sine_wave_meas #(
    parameter int CNT_W = 16,
    parameter int HYST  = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [7:0]       din,
    input  logic             din_vld,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       vmax,
    output logic [7:0]       vmin,
    output logic [7:0]       amp_pp,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);
    localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
    logic [0:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   period_r;
    logic [7:0]       run_max, run_min;
    logic             xing, to_hit;
    // A crossing exactly at the counter limit yields 2^CNT_W, clamped on output.
    assign period = period_r[CNT_W] ? '1 : period_r[CNT_W-1:0];
    assign to_hit = st == RUN && !xing && &cnt;
`ifdef SINE_MEAS_HYST_EN
    localparam logic [8:0] HI = 9'(128 + HYST), LO = 9'(128 - HYST);
    logic armed;
    assign xing = armed && {1'b0, din} >= HI;
    always_ff @(posedge Clk) begin
        if (Rst) armed <= 1'b0;
        else if (din_vld) armed <= xing ? 1'b0 : ({1'b0, din} <= LO) ? 1'b1 : armed;
    end
`else
    logic prev_lo, prev_ok;
    assign xing = prev_ok && prev_lo && din[7];
    always_ff @(posedge Clk) begin
        if (Rst) begin
            prev_lo <= 1'b0;
            prev_ok <= 1'b0;
        end else if (din_vld) begin
            prev_lo <= !din[7];
            prev_ok <= !to_hit;
        end
    end
`endif
    always_ff @(posedge Clk) begin
        if (Rst) begin
            st         <= IDLE;
            cnt        <= '0;
            period_r   <= '0;
            run_max    <= '0;
            run_min    <= '0;
            vmax       <= '0;
            vmin       <= '0;
            amp_pp     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (din_vld) begin
                if (xing) begin
                    if (st == RUN) begin
                        period_r   <= {1'b0, cnt} + (CNT_W + 1)'(1);
                        vmax       <= run_max;
                        vmin       <= run_min;
                        amp_pp     <= run_max - run_min;
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
                    end
                    st      <= RUN;
                    cnt     <= '0;
                    run_max <= din;
                    run_min <= din;
                end else if (to_hit) begin
                    timeout <= 1'b1;
                    locked  <= 1'b0;
                    st      <= IDLE;
                end else if (st == RUN) begin
                    cnt     <= cnt + CNT_W'(1);
                    run_max <= din > run_max ? din : run_max;
                    run_min <= din < run_min ? din : run_min;
                end
            end
        end
    end
endmodule

// File: tb/tb_sine_wave_meas.sv
// tb_sine_wave_meas: randomized and directed checks of sine_wave_meas against a sample-history model
module tb_sine_wave_meas;
    localparam int H = 4;
`ifdef SINE_MEAS_HYST_EN
    localparam int XK = 1;
`else
    localparam int XK = 0;
`endif
    logic        Clk = 1'b0, Rst = 1'b1, din_vld = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [15:0] period0;
    logic [7:0]  period1;
    logic [7:0]  vmax0, vmin0, amp0, vmax1, vmin1, amp1;
    logic        mv0, lk0, to0, mv1, lk1, to1;
    int          checks = 0, errors = 0;

    sine_wave_meas u16 (.Clk(Clk), .Rst(Rst), .din(din), .din_vld(din_vld), .period(period0),
        .vmax(vmax0), .vmin(vmin0), .amp_pp(amp0), .meas_valid(mv0), .locked(lk0), .timeout(to0));
    sine_wave_meas #(.CNT_W(8), .HYST(H)) u8 (.Clk(Clk), .Rst(Rst), .din(din), .din_vld(din_vld),
        .period(period1), .vmax(vmax1), .vmin(vmin1), .amp_pp(amp1), .meas_valid(mv1), .locked(lk1),
        .timeout(to1));

    always #5 Clk = ~Clk;

    // Model: full history of valid samples; each instance remembers where its open window starts.
    logic [7:0]  hist[$];
    int          ws[2];
    bit          run[2], pok[2], prev_lo[2], armed[2];
    logic [15:0] e_per[2];
    logic [7:0]  e_vmax[2], e_vmin[2], e_amp[2];
    logic        e_mv[2], e_lk[2], e_to[2];

    function automatic logic [42:0] obs(int i);
        return i == 0 ? {period0, vmax0, vmin0, amp0, mv0, lk0, to0}
                      : {8'h00, period1, vmax1, vmin1, amp1, mv1, lk1, to1};
    endfunction

    function automatic logic [42:0] expv(int i);
        return {e_per[i], e_vmax[i], e_vmin[i], e_amp[i], e_mv[i], e_lk[i], e_to[i]};
    endfunction

    function automatic int wlen(int i);
        return i == 0 ? 65536 : 256;
    endfunction

    function automatic logic [7:0] sine(int k);
        real r;
        r = 128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 32.0);
        return 8'($rtoi(r + 0.5));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ws[i] = 0; run[i] = 0; pok[i] = 0; prev_lo[i] = 0; armed[i] = 0;
            e_per[i] = 0; e_vmax[i] = 0; e_vmin[i] = 0; e_amp[i] = 0;
            e_mv[i] = 0; e_lk[i] = 0; e_to[i] = 0;
        end
    endtask

    task automatic model_sample(input logic [7:0] d);
        int cur;
        hist.push_back(d);
        cur = hist.size() - 1;
        for (int i = 0; i < 2; i++) begin
            int n;
            bit x;
            logic [7:0] mx, mn;
            n = cur - ws[i];
`ifdef SINE_MEAS_HYST_EN
            x = armed[i] && d >= 8'(128 + H);
            if (x) armed[i] = 0;
            else if (d <= 8'(128 - H)) armed[i] = 1;
`else
            x = pok[i] && prev_lo[i] && d >= 8'd128;
            prev_lo[i] = d < 8'd128;
            pok[i] = 1;
`endif
            if (x) begin
                if (run[i]) begin
                    mx = 8'd0; mn = 8'd255;
                    for (int j = ws[i]; j < cur; j++) begin
                        if (hist[j] > mx) mx = hist[j];
                        if (hist[j] < mn) mn = hist[j];
                    end
                    e_per[i] = 16'(n > wlen(i) - 1 ? wlen(i) - 1 : n);
                    e_vmax[i] = mx; e_vmin[i] = mn; e_amp[i] = mx - mn;
                    e_mv[i] = 1; e_lk[i] = 1;
                end
                run[i] = 1;
                ws[i] = cur;
            end else if (run[i] && n == wlen(i)) begin
                e_to[i] = 1; e_lk[i] = 0; run[i] = 0; pok[i] = 0;
            end
        end
    endtask

    task automatic step(input logic [7:0] d, input bit v);
        Rst = 1'b0; din = d; din_vld = v;
        @(posedge Clk); #1;
        for (int i = 0; i < 2; i++) begin e_mv[i] = 0; e_to[i] = 0; end
        if (v) model_sample(d);
    endtask

    task automatic do_reset(input int n);
        Rst = 1'b1; din_vld = 1'b1;
        repeat (n) begin din = 8'($urandom); @(posedge Clk); #1; end
        Rst = 1'b0;
        model_reset();
    endtask

    // Sine from phase 16 through the third crossing, so the last sample is a crossing.
    task automatic lock_wave();
        for (int c = 0; c <= 80 + XK; c++) step(sine((c + 16) % 32), 1);
    endtask

    task automatic test_reset();
        Rst = 1'b1; din_vld = 1'b1;
        for (int c = 0; c < 3; c++) begin
            din = 8'($urandom);
            @(posedge Clk); #1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== '0) begin errors++; $display("FAIL reset inst%0d: got %h expected 0", i, obs(i)); end
            end
        end
        model_reset();
        step(8'($urandom), 1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin errors++; $display("FAIL reset_after inst%0d: got %h expected %h", i, obs(i), expv(i)); end
        end
    endtask

    task automatic test_clean_sine();
        int last = -1, np = 0;
        do_reset(2);
        for (int c = 0; c < 192; c++) begin
            step(sine((c + 16) % 32), 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL sine inst%0d c=%0d: got %h expected %h", i, c, obs(i), expv(i)); end
            end
            if (mv0) begin
                checks++;
                if ((np == 0 && c != 48 + XK) || (np > 0 && c - last != 32) || period0 != 16'd32 ||
                    vmax0 != 8'd228 || vmin0 != 8'd28 || amp0 != 8'd200 || !lk0) begin
                    errors++;
                    $display("FAIL sine_pulse c=%0d last=%0d: got per=%0d max=%0d min=%0d amp=%0d expected 32/228/28/200", c, last, period0, vmax0, vmin0, amp0);
                end
                last = c; np++;
            end
        end
        checks++;
        if (np != 5) begin errors++; $display("FAIL sine_count: got %0d expected 5", np); end
    endtask

    task automatic test_gaps();
        int last = -1, np = 0, s = 0;
        bit v;
        do_reset(2);
        for (int c = 0; c < 300; c++) begin
            v = (c % 3) != 2;
            step(sine((s + 16) % 32), v);
            if (v) s++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL gaps inst%0d c=%0d: got %h expected %h", i, c, obs(i), expv(i)); end
            end
            if (mv0) begin
                checks++;
                if ((last >= 0 && c - last != 48) || period0 != 16'd32 || amp0 != 8'd200) begin
                    errors++;
                    $display("FAIL gaps_pulse c=%0d last=%0d: got per=%0d amp=%0d expected spacing 48 per 32 amp 200", c, last, period0, amp0);
                end
                last = c; np++;
            end
        end
        checks++;
        if (np != 5) begin errors++; $display("FAIL gaps_count: got %0d expected 5", np); end
    endtask

    task automatic test_timeout();
        int nto = 0, at = -1, first = -1;
        do_reset(2);
        lock_wave();
        for (int j = 1; j <= 300; j++) begin
            step(8'd200, 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL timeout inst%0d j=%0d: got %h expected %h", i, j, obs(i), expv(i)); end
            end
            if (to1) begin nto++; at = j; end
        end
        checks++;
        if (nto != 1 || at != 256) begin errors++; $display("FAIL timeout_pulse: got count %0d at %0d expected 1 at 256", nto, at); end
        checks++;
        if (lk1 !== 1'b0 || vmax1 != 8'd228 || vmin1 != 8'd28 || amp1 != 8'd200 || period1 != 8'd32) begin
            errors++;
            $display("FAIL timeout_hold: got lk=%0d max=%0d min=%0d amp=%0d per=%0d expected 0/228/28/200/32", lk1, vmax1, vmin1, amp1, period1);
        end
        for (int c = 0; c < 80; c++) begin
            step(sine((c + 16) % 32), 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL relock inst%0d c=%0d: got %h expected %h", i, c, obs(i), expv(i)); end
            end
            if (mv1 && first < 0) first = c;
        end
        checks++;
        if (first != 48 + XK) begin errors++; $display("FAIL relock_first: got %0d expected %0d", first, 48 + XK); end
    endtask

    task automatic test_saturate();
        do_reset(2);
        lock_wave();
        for (int j = 0; j < 255; j++) begin
            step(8'd50, 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL sat_fill inst%0d j=%0d: got %h expected %h", i, j, obs(i), expv(i)); end
            end
        end
        step(8'd200, 1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin errors++; $display("FAIL sat inst%0d: got %h expected %h", i, obs(i), expv(i)); end
        end
        checks++;
        if (!mv1 || to1 || period1 != 8'd255 || vmin1 != 8'd50 || vmax1 != sine(XK) || period0 != 16'd256) begin
            errors++;
            $display("FAIL sat_value: got mv=%0d to=%0d per8=%0d per16=%0d min=%0d max=%0d expected 1/0/255/256/50/%0d", mv1, to1, period1, period0, vmin1, vmax1, sine(XK));
        end
    endtask

    task automatic test_chatter();
        int np = 0, nto = 0;
        do_reset(2);
        lock_wave();
        for (int j = 0; j < 320; j++) begin
            step(j % 2 ? 8'd129 : 8'd127, 1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL chatter inst%0d j=%0d: got %h expected %h", i, j, obs(i), expv(i)); end
            end
            if (mv1) begin
                np++;
                if (np > 1) begin
                    checks++;
                    if (period1 != 8'd2 || amp1 != 8'd2) begin errors++; $display("FAIL chatter_pulse j=%0d: got per=%0d amp=%0d expected 2/2", j, period1, amp1); end
                end
            end
            if (to1) nto++;
        end
        checks++;
`ifdef SINE_MEAS_HYST_EN
        if (np != 0 || nto != 1) begin errors++; $display("FAIL chatter_count: got pulses %0d timeouts %0d expected 0/1", np, nto); end
`else
        if (np != 160 || nto != 0) begin errors++; $display("FAIL chatter_count: got pulses %0d timeouts %0d expected 160/0", np, nto); end
`endif
    endtask

    task automatic test_reset_mid();
        int nk = 0, k;
        bit got = 0;
        do_reset(2);
        lock_wave();
        for (int j = 0; j < 10; j++) step(sine((81 + XK + j + 16) % 32), 1);
        Rst = 1'b1; din_vld = 1'b1; din = 8'($urandom);
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== '0) begin errors++; $display("FAIL mid_reset inst%0d: got %h expected 0", i, obs(i)); end
        end
        for (int c = 91 + XK; c < 171 + XK; c++) begin
            k = (c + 16) % 32;
            step(sine(k), 1);
            if (k == XK) nk++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL mid inst%0d c=%0d: got %h expected %h", i, c, obs(i), expv(i)); end
            end
            if (mv0 && !got) begin
                got = 1;
                checks++;
                if (nk != 2 || k != XK || period0 != 16'd32) begin errors++; $display("FAIL mid_first: got crossing %0d per=%0d expected 2/32", nk, period0); end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL mid_pulse: got none expected one"); end
    endtask

    task automatic test_random();
        bit v;
        do_reset(2);
        for (int c = 0; c < 800; c++) begin
            v = $urandom_range(0, 9) != 0;
            step(8'($urandom), v);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin errors++; $display("FAIL random inst%0d c=%0d: got %h expected %h", i, c, obs(i), expv(i)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_sine();
        test_gaps();
        test_timeout();
        test_saturate();
        test_chatter();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
